multi_edge_detector: RTL and testbench
======================================

MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 Parameter N, default 4: number of independent input channels, N >= 1.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, >= 2.
REQ-003 Parameter DEBOUNCE_CYCLES, default 8: consecutive differing samples required before the debounced level changes, >= 1; 1 = no filtering.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 in  input  N  asynchronous raw inputs, one bit per channel.
REQ-007 mode  input  2  global event-capture mode: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 clear  input  N  per-channel clear of pending and overrun; level-sampled.
REQ-009 level  output  N  debounced, registered level per channel.
REQ-010 positive_edge  output  N  one-cycle pulse on a debounced 0->1 transition.
REQ-011 negative_edge  output  N  one-cycle pulse on a debounced 1->0 transition.
REQ-012 pending  output  N  sticky flag: a mode-qualified event occurred since the last clear.
REQ-013 overrun  output  N  sticky flag: a qualified event occurred while pending was already set.
REQ-014 any_pending  output  1  OR-reduction of pending, registered.

Function
REQ-015 Each channel SHALL pass in[i] through a SYNC_STAGES-deep flop chain; only the final stage (sync_out) feeds the rest of the logic.
REQ-016 Each channel SHALL hold a counter of width $clog2(DEBOUNCE_CYCLES+1).
- Edge with sync_out == level: counter <= 0.
- Edge with sync_out != level and counter < DEBOUNCE_CYCLES-1: counter increments.
- Edge with sync_out != level and counter == DEBOUNCE_CYCLES-1: level <= sync_out, counter <= 0, matching edge pulse asserted.
REQ-017 Latency: in[i] changes before edge 0 (the first edge that samples it) and stays constant. level and the edge pulse SHALL then be valid in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-018 A glitch on sync_out that lasts fewer than DEBOUNCE_CYCLES samples SHALL produce no level change and no pulse, and SHALL reset the counter.
REQ-019 positive_edge and negative_edge SHALL each be high for exactly one cycle per transition and SHALL never be high together on the same channel.
REQ-020 A qualified event is a positive_edge pulse with mode[0]=1, or a negative_edge pulse with mode[1]=1. A qualified event SHALL set pending[i] on the same edge that the pulse is generated.
REQ-021 A qualified event while pending[i]=1 SHALL set overrun[i]. pending stays 1.
REQ-022 clear[i]=1 SHALL clear pending[i] and overrun[i] on that edge.
REQ-023 If clear[i] and a qualified event occur on the same edge: set wins, pending[i]=1 and overrun[i]=0.
REQ-024 Changing mode SHALL affect only events generated on or after the edge at which the new value is sampled; existing flags are unchanged.
REQ-025 Channels SHALL be fully independent; simultaneous events on all N channels SHALL all be captured.
REQ-026 any_pending SHALL equal the OR of pending as of the previous edge (one-cycle lag).

Reset
REQ-027 While rst=0 at a rising edge, the following SHALL all be 0 on that edge: synchroniser flops, counters, level, positive_edge, negative_edge, pending, overrun, any_pending.
REQ-028 Reset mid-debounce SHALL discard the partial count. No pulse SHALL follow reset release unless the input again satisfies REQ-016.
REQ-029 An input held high through reset SHALL yield one positive_edge after release, at the latency in REQ-017.

Verification (N=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, mode=11 unless noted)
REQ-030 Clean step: in[0] 0->1 before edge 0 and held -> level[0]=1 and positive_edge[0] pulse for exactly one cycle after edge 5; pending[0]=1 from that edge; any_pending=1 one cycle later.
REQ-031 Bounce: in[1] high for 3 cycles, low for 1, then high for 6 -> exactly one positive_edge[1], timed 5 edges after the final rise is sampled; no negative_edge[1].
REQ-032 Mode filter: mode=01, in[2] rises then falls, each held 10 cycles -> both pulses seen; pending[2] set only by the rise; overrun[2]=0.
REQ-033 Overrun and collision: two qualified events on channel 3 with no clear -> pending[3]=1 and overrun[3]=1. Then clear[3] on the same edge as a third event -> pending[3]=1, overrun[3]=0.
REQ-034 Reset: rst=0 asserted for one edge mid-count -> all outputs 0. Input held high through reset -> single positive_edge 5 edges after release.
REQ-035 Random stimulus on all channels (random hold 1..20 cycles) against a reference model:
- level and pulses match the model.
- positive_edge and negative_edge are never high together on a channel.
- pulses strictly alternate per channel.

Source files
------------

// File: rtl/multi_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module      : multi_edge_detector
//  Description : N-channel input conditioner. Each channel synchronises an
//                asynchronous input, debounces it, emits one-cycle rise/fall
//                pulses, and captures mode-qualified events into sticky
//                pending/overrun flags with per-channel clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_edge_detector #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic [1:0]   mode,
  input  logic [N-1:0] clear,
  output logic [N-1:0] level,
  output logic [N-1:0] positive_edge,
  output logic [N-1:0] negative_edge,
  output logic [N-1:0] pending,
  output logic [N-1:0] overrun,
  output logic         any_pending
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; the extra headroom keeps the
  // width legal when DEBOUNCE_CYCLES is 1.
  localparam int                c_cnt_w    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [c_cnt_w-1:0]     r_cnt;
      logic                   r_level;
      logic                   r_pos;
      logic                   r_neg;
      logic                   r_pend;
      logic                   r_ovr;

      logic w_sync_out;
      logic w_differs;
      logic w_commit;
      logic w_rise;
      logic w_fall;
      logic w_qual;

      // Only the last synchroniser stage is allowed to touch downstream logic.
      assign w_sync_out = r_sync[SYNC_STAGES-1];
      assign w_differs  = (w_sync_out != r_level);
      // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
      assign w_commit   = w_differs && (r_cnt == c_cnt_last);
      assign w_rise     = w_commit && w_sync_out;
      assign w_fall     = w_commit && !w_sync_out;
      assign w_qual     = (w_rise && mode[0]) || (w_fall && mode[1]);

      // Synchroniser chain: shift the raw input towards the last stage.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], in[g]};
        end
      end

      // Debounce counter, filtered level and one-cycle transition pulses.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
          r_pos   <= 1'b0;
          r_neg   <= 1'b0;
        end else begin
          r_pos <= w_rise;
          r_neg <= w_fall;
          if (!w_differs) begin
            r_cnt <= '0;
          end else if (w_commit) begin
            r_level <= w_sync_out;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      // Sticky event flags; a new event beats a simultaneous clear.
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_pend <= 1'b0;
          r_ovr  <= 1'b0;
        end else if (w_qual) begin
          r_pend <= 1'b1;
          r_ovr  <= clear[g] ? 1'b0 : (r_ovr | r_pend);
        end else if (clear[g]) begin
          r_pend <= 1'b0;
          r_ovr  <= 1'b0;
        end
      end

      assign level[g]         = r_level;
      assign positive_edge[g] = r_pos;
      assign negative_edge[g] = r_neg;
      assign pending[g]       = r_pend;
      assign overrun[g]       = r_ovr;
    end
  endgenerate

  // Summary flag lags pending by one cycle so it stays a clean flop output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      any_pending <= 1'b0;
    end else begin
      any_pending <= |pending;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_edge_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_edge_detector
//  Description : Directed and random self-checking bench for
//                multi_edge_detector (N=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_edge_detector;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DC   = 4;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic [N-1:0] in    = '0;
  logic [1:0]   mode  = 2'b11;
  logic [N-1:0] clear = '0;
  logic [N-1:0] level;
  logic [N-1:0] positive_edge;
  logic [N-1:0] negative_edge;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;
  logic         any_pending;

  multi_edge_detector #(
    .N               (N),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in            (in),
    .mode          (mode),
    .clear         (clear),
    .level         (level),
    .positive_edge (positive_edge),
    .negative_edge (negative_edge),
    .pending       (pending),
    .overrun       (overrun),
    .any_pending   (any_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] pe;
    logic [N-1:0] ne;
    logic [N-1:0] pend;
    logic [N-1:0] ovr;
    logic         anyp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model state
  logic [SYNC-1:0] m_sync [N] = '{default: '0};
  int              m_run  [N] = '{default: 0};
  logic [N-1:0]    m_level = '0;
  logic [N-1:0]    m_pe    = '0;
  logic [N-1:0]    m_ne    = '0;
  logic [N-1:0]    m_pend  = '0;
  logic [N-1:0]    m_ovr   = '0;
  logic            m_anyp  = 1'b0;

  logic [N-1:0] next_rise = '1;
  int           pe_cnt [N] = '{default: 0};
  int           ne_cnt [N] = '{default: 0};
  int           hold   [N];
  int           rise_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Advance the reference model across one rising edge using the current inputs.
  task automatic model_edge(output exp_t e);
    logic so;
    logic rise;
    logic fall;
    logic anyp_next;
    anyp_next = |m_pend;
    if (!rst) begin
      for (int ch = 0; ch < N; ch++) begin
        m_sync[ch] = '0;
        m_run[ch]  = 0;
      end
      m_level = '0;
      m_pe    = '0;
      m_ne    = '0;
      m_pend  = '0;
      m_ovr   = '0;
      m_anyp  = 1'b0;
    end else begin
      m_anyp = anyp_next;
      for (int ch = 0; ch < N; ch++) begin
        so   = m_sync[ch][SYNC-1];
        rise = 1'b0;
        fall = 1'b0;
        if (so != m_level[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DC) begin
            m_level[ch] = so;
            m_run[ch]   = 0;
            rise        = so;
            fall        = ~so;
          end
        end else begin
          m_run[ch] = 0;
        end
        m_sync[ch] = {m_sync[ch][SYNC-2:0], in[ch]};
        m_pe[ch]   = rise;
        m_ne[ch]   = fall;
        if ((rise && mode[0]) || (fall && mode[1])) begin
          m_ovr[ch]  = clear[ch] ? 1'b0 : (m_ovr[ch] | m_pend[ch]);
          m_pend[ch] = 1'b1;
        end else if (clear[ch]) begin
          m_pend[ch] = 1'b0;
          m_ovr[ch]  = 1'b0;
        end
      end
    end
    e.level = m_level;
    e.pe    = m_pe;
    e.ne    = m_ne;
    e.pend  = m_pend;
    e.ovr   = m_ovr;
    e.anyp  = m_anyp;
  endtask

  // One clock: predict, let the edge happen, then compare just after it.
  task automatic step();
    exp_t e;
    model_edge(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    chk("level",       32'(level),         32'(e.level));
    chk("pos_edge",    32'(positive_edge), 32'(e.pe));
    chk("neg_edge",    32'(negative_edge), 32'(e.ne));
    chk("pending",     32'(pending),       32'(e.pend));
    chk("overrun",     32'(overrun),       32'(e.ovr));
    chk("any_pending", 32'(any_pending),   32'(e.anyp));
    chk("pulse_excl",  32'(positive_edge & negative_edge), 32'd0);
    if (!rst) begin
      next_rise = '1;
    end else begin
      for (int ch = 0; ch < N; ch++) begin
        if (positive_edge[ch] === 1'b1) begin
          chk("alt_rise", 32'(next_rise[ch]), 32'd1);
          next_rise[ch] = 1'b0;
          pe_cnt[ch]++;
        end
        if (negative_edge[ch] === 1'b1) begin
          chk("alt_fall", 32'(next_rise[ch]), 32'd0);
          next_rise[ch] = 1'b1;
          ne_cnt[ch]++;
        end
      end
    end
  endtask

  task automatic clr_counts();
    for (int ch = 0; ch < N; ch++) begin
      pe_cnt[ch] = 0;
      ne_cnt[ch] = 0;
    end
  endtask

  // Directed scenarios followed by random stimulus.
  initial begin
    // Reset state
    rst = 1'b0; in = '0; mode = 2'b11; clear = '0;
    repeat (3) step();
    chk("rst_level", 32'(level),       32'd0);
    chk("rst_pend",  32'(pending),     32'd0);
    chk("rst_anyp",  32'(any_pending), 32'd0);
    rst = 1'b1;
    repeat (2) step();

    // Clean step on channel 0: pulse visible after edge 5
    in[0] = 1'b1;
    repeat (5) step();
    chk("step_pre_level", 32'(level), 32'd0);
    step();
    chk("step_level", 32'(level),         32'h1);
    chk("step_pulse", 32'(positive_edge), 32'h1);
    chk("step_pend",  32'(pending),       32'h1);
    chk("step_anyp0", 32'(any_pending),   32'd0);
    step();
    chk("step_pulse_end", 32'(positive_edge), 32'd0);
    chk("step_anyp1",     32'(any_pending),   32'd1);
    repeat (4) step();

    // Bounce on channel 1: 3 high, 1 low, then steady high
    clr_counts();
    in[1] = 1'b1;
    repeat (3) step();
    in[1] = 1'b0;
    step();
    in[1] = 1'b1;
    rise_at = -1;
    for (int j = 0; j < 10; j++) begin
      step();
      if (positive_edge[1] === 1'b1) rise_at = j;
    end
    chk("bounce_time",  32'(rise_at),   32'd5);
    chk("bounce_rises", 32'(pe_cnt[1]), 32'd1);
    chk("bounce_falls", 32'(ne_cnt[1]), 32'd0);

    // Mode filter on channel 2: only rising events qualify
    clr_counts();
    mode = 2'b01;
    in[2] = 1'b1;
    repeat (10) step();
    in[2] = 1'b0;
    repeat (10) step();
    chk("mode_rises", 32'(pe_cnt[2]),   32'd1);
    chk("mode_falls", 32'(ne_cnt[2]),   32'd1);
    chk("mode_pend",  32'(pending[2]),  32'd1);
    chk("mode_ovr",   32'(overrun[2]),  32'd0);

    // Overrun, then clear colliding with a third event on channel 3
    mode = 2'b11;
    in[3] = 1'b1;
    repeat (10) step();
    in[3] = 1'b0;
    repeat (10) step();
    chk("ovr_pend", 32'(pending[3]), 32'd1);
    chk("ovr_set",  32'(overrun[3]), 32'd1);
    in[3] = 1'b1;
    repeat (5) step();
    clear[3] = 1'b1;
    step();
    clear[3] = 1'b0;
    chk("coll_pulse", 32'(positive_edge[3]), 32'd1);
    chk("coll_pend",  32'(pending[3]),       32'd1);
    chk("coll_ovr",   32'(overrun[3]),       32'd0);
    repeat (4) step();

    // Reset mid-count with inputs held high through it
    in = '0;
    repeat (10) step();
    in = '1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("mrst_level", 32'(level),         32'd0);
    chk("mrst_pos",   32'(positive_edge), 32'd0);
    chk("mrst_neg",   32'(negative_edge), 32'd0);
    chk("mrst_pend",  32'(pending),       32'd0);
    chk("mrst_ovr",   32'(overrun),       32'd0);
    chk("mrst_anyp",  32'(any_pending),   32'd0);
    rst = 1'b1;
    for (int j = 0; j < 8; j++) begin
      step();
      if (j == 5) chk("rel_pulse",    32'(positive_edge), 32'hF);
      else        chk("rel_no_pulse", 32'(positive_edge), 32'd0);
    end

    // Random holds, clears and mode changes against the model
    for (int c = 0; c < N; c++) hold[c] = int'($urandom_range(1, 20));
    repeat (800) begin
      for (int c = 0; c < N; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          in[c]   = ~in[c];
          hold[c] = int'($urandom_range(1, 20));
        end
        clear[c] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      step();
    end
    clear = '0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
